aes_iter_core: RTL

//  Iterative AES encryption core, one full round per clock. Parametrised for AES-128 or AES-256.

---
 rtl/aes_pkg.sv | 94 +++++++++
 rtl/aes_key_step.sv | 36 +++
 rtl/aes_iter_core.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared types, round-constant table and AES byte transforms
//                (SubBytes, ShiftRows, MixColumns) for the iterative core.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } aes_fsm_t;

   // Round constants, first entry in the MSBs
   localparam logic [79:0] RCON_TBL = 80'h01_02_04_08_10_20_40_80_1b_36;

   function automatic int aes_nr(input int key_bits);
      return (key_bits == 256) ? 14 : 10;
   endfunction

   // Table lookup that yields 0 for out-of-range indices instead of X
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] v;
      v = 8'h00;
      for (int i = 0; i < 10; i++)
         if (idx == 4'(i)) v = RCON_TBL[79 - 8*i -: 8];
      return v;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box computed as x^254 (multiplicative inverse, 0 -> 0) then the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] inv;
      logic [7:0] pw;
      inv = 8'h01;
      pw  = a;
      for (int i = 0; i < 7; i++) begin
         pw  = gf_mul(pw, pw);
         inv = gf_mul(inv, pw);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
      return o;
   endfunction

   // Byte n lives at bits [127-8n -: 8]; row = n%4, column = n/4
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
         o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
         o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
         o[103 - 32*c -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_step
//  Description : One combinational key-expansion step producing four new
//                schedule words from the previous block and the last word.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] i_prev,
   input  logic [31:0]  i_last_word,
   input  logic         i_rot,
   input  logic [7:0]   i_rc,
   output logic [127:0] o_next
);

   logic [31:0] w_t;
   logic [31:0] w_sub;
   logic [31:0] w_mix;
   logic [31:0] w_w0, w_w1, w_w2, w_w3;

   assign w_t   = i_rot ? {i_last_word[23:0], i_last_word[31:24]} : i_last_word;
   // SubWord via the shared byte-substitution, keeping only the top word
   assign w_sub = 32'(sub_bytes({w_t, 96'h0}) >> 96);
   assign w_mix = w_sub ^ (i_rot ? {i_rc, 24'h0} : 32'h0);

   assign w_w0 = i_prev[127:96] ^ w_mix;
   assign w_w1 = i_prev[95:64]  ^ w_w0;
   assign w_w2 = i_prev[63:32]  ^ w_w1;
   assign w_w3 = i_prev[31:0]   ^ w_w2;

   assign o_next = {w_w0, w_w1, w_w2, w_w3};

endmodule
`default_nettype wire

// File: rtl/aes_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : aes_iter_core
//  Description : Iterative AES-128/256 encryption, one round per clock, with
//                valid/ready streams on both sides and on-the-fly key expansion.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_iter_core
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        in_data,
   input  logic [KEY_BITS-1:0] in_key,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        out_data
);

   localparam int         NR          = aes_nr(KEY_BITS);
   localparam logic [3:0] c_NR_LAST   = 4'(NR);

   generate
      if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
         $error("aes_iter_core: KEY_BITS must be 128 or 256");
      end
   endgenerate

   aes_fsm_t     r_fsm;
   logic [127:0] r_state;
   logic [3:0]   r_round;

   logic         w_accept;
   logic         w_last;
   logic [127:0] w_k0;
   logic [127:0] w_rkey;
   logic [127:0] w_sr;
   logic [127:0] w_mc;
   logic [127:0] w_round_out;

   assign in_ready  = (r_fsm == IDLE) | ((r_fsm == DONE) & out_ready);
   assign out_valid = (r_fsm == DONE);
   assign out_data  = r_state;

   assign w_accept = in_valid & in_ready;
   assign w_last   = (r_round == c_NR_LAST);
   assign w_k0     = in_key[KEY_BITS-1 -: 128];

   // Final round skips MixColumns
   assign w_sr        = shift_rows(sub_bytes(r_state));
   assign w_mc        = mix_columns(w_sr);
   assign w_round_out = (w_last ? w_sr : w_mc) ^ w_rkey;

   generate
      if (KEY_BITS == 128) begin : g_k128
         logic [127:0] r_kcur;
         logic [127:0] w_knext;

         aes_key_step u_key_step (
            .i_prev      (r_kcur),
            .i_last_word (r_kcur[31:0]),
            .i_rot       (1'b1),
            .i_rc        (rcon(r_round - 4'd1)),
            .o_next      (w_knext)
         );

         assign w_rkey = w_knext;

         // Current round key: K0 on accept, advanced once per executed round
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)             r_kcur <= '0;
            else if (w_accept)      r_kcur <= w_k0;
            else if (r_fsm == RUN)  r_kcur <= w_knext;
         end
      end else begin : g_k256
         logic [127:0] r_ka;
         logic [127:0] r_kb;
         logic [127:0] w_knext;
         logic [4:0]   w_rp1;

         // Schedule blocks alternate RotWord+Rcon (even index) and SubWord only
         assign w_rp1 = {1'b0, r_round} + 5'd1;

         aes_key_step u_key_step (
            .i_prev      (r_ka),
            .i_last_word (r_kb[31:0]),
            .i_rot       (~w_rp1[0]),
            .i_rc        (rcon(w_rp1[4:1] - 4'd1)),
            .o_next      (w_knext)
         );

         assign w_rkey = r_kb;

         // Two-block sliding window over the expanded key
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_ka <= '0;
               r_kb <= '0;
            end else if (w_accept) begin
               r_ka <= w_k0;
               r_kb <= in_key[127:0];
            end else if (r_fsm == RUN) begin
               r_ka <= r_kb;
               r_kb <= w_knext;
            end
         end
      end
   endgenerate

   // Control FSM with the cipher state and round counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm   <= IDLE;
         r_state <= '0;
         r_round <= 4'd0;
      end else if (w_accept) begin
         r_state <= in_data ^ w_k0;
         r_round <= 4'd1;
         r_fsm   <= RUN;
      end else begin
         case (r_fsm)
            RUN: begin
               r_state <= w_round_out;
               if (w_last) r_fsm   <= DONE;
               else        r_round <= r_round + 4'd1;
            end
            DONE: begin
               if (out_ready) r_fsm <= IDLE;
            end
            IDLE: begin
               r_fsm <= IDLE;
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
